// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared LZ77 codec parameters, field widths and decoder state encoding
package lz77_pkg;

  localparam int SEARCH_SIZE = 9;
  localparam int SYM_W       = 4;
  localparam int MAX_LEN     = 7;
  localparam logic [7:0] EOS_CHAR = 8'h24;

  localparam int OFFSET_W = 4;
  localparam int LEN_W    = 3;
  localparam int CHAR_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } dec_state_e;

endpackage

// File: rtl/lz77_search_buf.sv
// rtl/lz77_search_buf.sv - sliding search buffer: shift register with range-checked indexed read
module lz77_search_buf
  import lz77_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic [SYM_W-1:0]    din,
  input  logic [OFFSET_W-1:0] rd_idx,
  output logic [SYM_W-1:0]    rd_data
);

  localparam logic [OFFSET_W-1:0] DEPTH = OFFSET_W'(SEARCH_SIZE);

  logic [SYM_W-1:0] mem [SEARCH_SIZE];

  // Entry 0 is the most recent symbol; every shift ages all entries by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SEARCH_SIZE; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < SEARCH_SIZE; i++) mem[i] <= mem[i-1];
    end
  end

  // Offsets past the window read as symbol 0 rather than flagging an error.
  always_comb begin
    rd_data = '0;
    if (rd_idx < DEPTH) rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 codeword decoder emitting one 4-bit symbol per cycle
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [LEN_W-1:0]    match_len,
  input  logic [CHAR_W-1:0]   char_nxt,
  output logic                out_valid,
  output logic [7:0]          out_char,
  output logic                encode,
  output logic                finish
);

  dec_state_e state, state_next;

  logic [OFFSET_W-1:0] off_lat;
  logic [LEN_W-1:0]    cnt;
  logic [CHAR_W-1:0]   char_lat;
  logic                shift_en;
  logic [SYM_W-1:0]    sym_out;
  logic [SYM_W-1:0]    rd_data;
  logic                accept;

  assign accept = code_valid && code_ready;

  lz77_search_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (sym_out),
    .rd_idx   (off_lat),
    .rd_data  (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the codeword on accept; the copy counter counts down the remaining matches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_lat  <= '0;
      cnt      <= '0;
      char_lat <= '0;
    end else if (accept) begin
      off_lat  <= offset;
      cnt      <= match_len;
      char_lat <= char_nxt;
    end else if (state == COPY) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Next-state and output decode; the offset stays fixed so overlapping copies just work.
  always_comb begin
    state_next = state;
    code_ready = 1'b0;
    out_valid  = 1'b0;
    sym_out    = '0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        code_ready = 1'b1;
        if (code_valid) begin
          if (match_len != '0)         state_next = COPY;
          else if (char_nxt == EOS_CHAR) state_next = DONE;
          else                         state_next = LIT;
        end
      end
      COPY: begin
        out_valid = 1'b1;
        sym_out   = rd_data;
        shift_en  = 1'b1;
        if (cnt == 3'd1) state_next = (char_lat == EOS_CHAR) ? DONE : LIT;
      end
      LIT: begin
        out_valid  = 1'b1;
        sym_out    = char_lat[SYM_W-1:0];
        shift_en   = 1'b1;
        state_next = IDLE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_char = {4'h0, sym_out};
  assign encode   = 1'b0;
  assign finish   = (state == DONE);

endmodule

// File: tb/tb_lz77_decoder.sv
// tb/tb_lz77_decoder.sv - self-checking bench for lz77_decoder against a history-queue model
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [3:0] offset = '0;
  logic [2:0] match_len = '0;
  logic [7:0] char_nxt = '0;
  logic       out_valid;
  logic [7:0] out_char;
  logic       encode;
  logic       finish;

  int errors = 0;
  int checks = 0;

  int hist[$];
  int expq[$];

  lz77_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .offset     (offset),
    .match_len  (match_len),
    .char_nxt   (char_nxt),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .encode     (encode),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: window starts as zeros; each copy reads distance 'off' back in the
  // decoded history (0 = newest); offsets beyond the window read as 0.
  task automatic model_reset();
    hist.delete();
    expq.delete();
    for (int i = 0; i < 9; i++) hist.push_back(0);
  endtask

  task automatic model_decode(input int off, input int len, input int ch);
    int s;
    for (int k = 0; k < len; k++) begin
      s = (off < 9) ? hist[hist.size() - 1 - off] : 0;
      hist.push_back(s);
      expq.push_back(s);
    end
    if (ch != 8'h24) begin
      hist.push_back(ch & 15);
      expq.push_back(ch & 15);
    end
  endtask

  // Every emitted symbol is matched against the model's expected stream.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      check("out_ready_low", code_ready, 0);
      if (expq.size() == 0) check("unexpected_out", out_char, 8'hff);
      else                  check("out_char", out_char, expq.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    code_valid = 1'b0;
    #1;
    check("rst_ready", code_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_char", out_char, 0);
    check("rst_finish", finish, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_code(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    int n = 0;
    while (!code_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    offset = o; match_len = l; char_nxt = c; code_valid = 1'b1;
    @(posedge clk);
    model_decode(o, l, c);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (12) @(negedge clk);
    check(tag, expq.size(), 0);
  endtask

  initial begin
    int o, l, c;

    // Idle after reset.
    do_reset();
    repeat (20) begin
      @(negedge clk);
      check("idle_ready", code_ready, 1);
      check("idle_valid", out_valid, 0);
      check("idle_finish", finish, 0);
      check("idle_encode", encode, 0);
    end

    // Literals then an offset-1 copy: 01,02,01,02,01,03 with back-to-back copies.
    send_code(4'd0, 3'd0, 8'h31);
    send_code(4'd0, 3'd0, 8'h32);
    send_code(4'd1, 3'd3, 8'h33);
    check("copy_valid0", out_valid, 1);
    repeat (3) begin
      @(negedge clk);
      check("copy_valid", out_valid, 1);
    end
    drain("drain_basic");

    // Overlapping run: 05 then seven 05 and 06, code_ready low for all 8 outputs.
    do_reset();
    send_code(4'd0, 3'd0, 8'h35);
    send_code(4'd0, 3'd7, 8'h36);
    check("run_ready0", code_ready, 0);
    check("run_valid0", out_valid, 1);
    repeat (7) begin
      @(negedge clk);
      check("run_ready", code_ready, 0);
      check("run_valid", out_valid, 1);
    end
    drain("drain_run");

    // EOS as the very first codeword.
    do_reset();
    send_code(4'd0, 3'd0, 8'h24);
    check("eos0_finish", finish, 1);
    check("eos0_valid", out_valid, 0);
    offset = 4'd0; match_len = 3'd0; char_nxt = 8'h31; code_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("eos0_ready", code_ready, 0);
      check("eos0_sticky", finish, 1);
      check("eos0_novalid", out_valid, 0);
    end
    code_valid = 1'b0;
    drain("drain_eos0");

    // EOS carried by a copy: outputs 01,02 and finish the cycle after 02.
    do_reset();
    send_code(4'd0, 3'd0, 8'h31);
    send_code(4'd0, 3'd0, 8'h32);
    send_code(4'd0, 3'd0, 8'h33);
    send_code(4'd2, 3'd2, 8'h24);
    check("eosc_fin0", finish, 0);
    @(negedge clk);
    check("eosc_fin1", finish, 0);
    check("eosc_last", out_valid, 1);
    @(negedge clk);
    check("eosc_fin2", finish, 1);
    check("eosc_novalid", out_valid, 0);
    drain("drain_eosc");

    // Reset in the middle of a copy clears everything, window included.
    do_reset();
    send_code(4'd0, 3'd0, 8'h39);
    send_code(4'd0, 3'd5, 8'h37);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_ready", code_ready, 1);
    check("mid_char", out_char, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_code(4'd3, 3'd1, 8'h34);
    drain("drain_mid");

    // Random codeword streams including illegal offsets, ended by a random EOS copy.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        o = $urandom_range(15, 0);
        l = $urandom_range(7, 0);
        c = $urandom_range(255, 0);
        if (c == 8'h24) c = 8'h25;
        send_code(o[3:0], l[2:0], c[7:0]);
      end
      o = $urandom_range(15, 0);
      l = $urandom_range(7, 0);
      send_code(o[3:0], l[2:0], 8'h24);
      drain("drain_rand");
      check("rand_finish", finish, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
